alu_arbiter: RTL
================

# alu_arbiter

Two-port round-robin arbiter and sequencer in front of the shared fixed-point `alu`. It accepts operations from two independent requesters over valid/ready handshakes and drives the ALU's single issue port. It holds the grant for the full 8-beat matrix-transpose (inst 4'b1001) input burst and routes every ALU result back to the requester that issued it. Only one operation is in flight at a time.

## Interface
- `INST_W`, default 4: ALU instruction width.
- `DATA_W`, default 16: ALU operand/result width.
- `MAT_INST`, default 4'b1001: opcode that triggers the 8-beat input / 8-result burst.
- `i_clk`  in  1  clock, rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req0_valid`, `i_req1_valid`  in  1  requester has a beat.
- `o_req0_ready`, `o_req1_ready`  out  1  beat accepted this cycle when valid&&ready.
- `i_req0_inst`, `i_req1_inst`  in  INST_W  opcode.
- `i_req0_a`, `i_req1_a`, `i_req0_b`, `i_req1_b`  in  DATA_W  operands.
- `o_rsp0_valid`, `o_rsp1_valid`  out  1  result for requester 0/1.
- `o_rsp_data`  out  DATA_W  shared result bus.
- `o_alu_valid`  out  1  to ALU `i_in_valid`.
- `o_alu_inst`  out  INST_W  to ALU `i_inst`.
- `o_alu_a`, `o_alu_b`  out  DATA_W  to ALU operands.
- `i_alu_busy`  in  1  from ALU `o_busy`.
- `i_alu_out_valid`  in  1  from ALU `o_out_valid`.
- `i_alu_data`  in  DATA_W  from ALU `o_data`.
- `o_timeout`  out  1  watchdog pulse (see Configuration).

## Operation
- States:
  - IDLE: no operation owned.
  - MAT_ISSUE: owner locked, issuing beats 2-8 of a matrix burst.
  - WAIT_RSP: waiting for the expected result count.
- Registers:
  - `owner` (1 bit).
  - `last` (last-served requester, reset 1 so req0 wins the first tie).
  - `beat_cnt` (3 bits).
  - `rsp_cnt` (4 bits).
  - `rsp_exp` (1 or 8).
- IDLE grant:
  - Only when `i_alu_busy`==0.
  - Single valid requester wins.
  - Both valid: the requester != `last` wins.
  - `o_reqN_ready`=1 for the winner only, combinationally.
- ALU drive:
  - `o_alu_valid` = handshake of the granted requester.
  - `o_alu_inst`/`a`/`b` = granted requester's fields, muxed combinationally.
  - When no handshake occurs, ALU outputs are 0.
- On handshake in IDLE:
  - Set `owner` and `last` to the winner; clear `rsp_cnt`.
  - If inst==MAT_INST: `beat_cnt`=1, `rsp_exp`=8, go to MAT_ISSUE.
  - Otherwise: `rsp_exp`=1, go to WAIT_RSP.
- MAT_ISSUE:
  - Only the owner sees ready=1; the non-owner is never ready.
  - `o_alu_inst` is forced to MAT_INST regardless of the requester's inst.
  - Gaps in owner valid are allowed; `beat_cnt` advances per handshake.
  - On the handshake with `beat_cnt`==7: go to WAIT_RSP.
- WAIT_RSP:
  - Both readies are 0.
  - Each `i_alu_out_valid` increments `rsp_cnt`.
  - When `rsp_cnt` reaches `rsp_exp`: go to IDLE.
- Response routing:
  - On each `i_alu_out_valid`, register `o_rsp_data` <= `i_alu_data` and `o_rspN_valid` <= (N==owner).
  - Otherwise both rsp valids are 0 and `o_rsp_data` holds.
- Results arriving in IDLE or MAT_ISSUE are protocol errors: dropped, and no rsp valid is raised.

## Timing
- Reset (sync, `i_rst_n`=0 at the edge):
  - State IDLE; `last`=1; all counters 0.
  - All rsp valids 0, `o_rsp_data`=0, `o_timeout`=0.
  - Combinational outputs resolve to 0 while in IDLE with no grant.
  - Reset mid-burst abandons the operation; no response is emitted.
- Single op, handshake at cycle T:
  - ALU `o_out_valid` at T+1.
  - `o_rspN_valid` high for one cycle at T+2.
  - State is IDLE at T+2; the next grant is possible at T+2 once the ALU has dropped busy.
- Matrix burst:
  - 8 beats at ≥8 cycles; 8 results.
  - Each result is forwarded 1 cycle after the matching `i_alu_out_valid`.
  - IDLE is reached the cycle after the 8th result.
- Simultaneous valids in IDLE on consecutive ops alternate 0,1,0,1…
- A requester holding valid while the other is served must keep its fields stable until ready.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A 7-bit watchdog counts cycles in WAIT_RSP since the last result or state entry.
  - At 64 cycles: `o_timeout` pulses for 1 cycle, state returns to IDLE, and the pending operation is discarded.
- Not defined:
  - WAIT_RSP waits indefinitely.
  - `o_timeout` is tied to 0.

## Test plan
- Reset, then req0 ADD (inst 0) a=16'h0400 b=16'h0400, ALU model returns 16'h0800 → `o_rsp0_valid` at T+2 with data 16'h0800; `o_rsp1_valid` stays 0.
- req0 and req1 both valid continuously with SUB ops → grants alternate 0,1,0,1; each rsp routed to its issuer; no ready while in WAIT_RSP.
- req1 issues MAT_INST while req0 is valid → req0 ready stays 0 through all 8 beats (including a 2-cycle gap after beat 3) and all 8 results; 8 `o_rsp1_valid` pulses; req0 is granted immediately after.
- `i_rst_n` asserted low after beat 4 of a matrix burst → next cycle state IDLE, rsp valids 0; a subsequent ADD from req0 completes normally.
- With `ALU_ARB_TIMEOUT_EN`, ALU model withholds its result → `o_timeout` pulses 64 cycles after the handshake, then a new grant is accepted.
- `i_alu_busy` held high in IDLE with both requesters valid → both readies stay 0; the grant happens the cycle busy falls.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the shared ALU issue port.
// Optional WAIT_RSP watchdog is compiled in when ALU_ARB_TIMEOUT_EN is defined.
//
// state     | meaning
// IDLE      | no operation owned, grant on ALU not busy
// MAT_ISSUE | owner locked, issuing beats 2-8 of a matrix burst
// WAIT_RSP  | waiting for the expected result count
module alu_arbiter #(
  parameter int unsigned       INST_W   = 4,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [INST_W-1:0] MAT_INST = 4'b1001
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  input  logic              i_req1_valid,
  output logic              o_req0_ready,
  output logic              o_req1_ready,
  input  logic [INST_W-1:0] i_req0_inst,
  input  logic [INST_W-1:0] i_req1_inst,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic [DATA_W-1:0] i_req1_b,
  output logic              o_rsp0_valid,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_alu_valid,
  output logic [INST_W-1:0] o_alu_inst,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic              i_alu_busy,
  input  logic              i_alu_out_valid,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MAT_ISSUE = 2'd1,
    WAIT_RSP  = 2'd2
  } state_t;

  state_t              state_q;
  logic                owner_q;
  logic                last_q;
  logic [2:0]          beat_cnt_q;
  logic [2:0]          beat_cnt_d;
  logic [3:0]          rsp_cnt_q;
  logic [3:0]          rsp_cnt_d;
  logic [3:0]          rsp_exp_q;
  logic                rsp0_valid_q;
  logic                rsp1_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;

  logic                grant0;
  logic                grant1;
  logic                hs0;
  logic                hs1;
  logic                hs_any;
  logic [INST_W-1:0]   hs_inst;

  // Grants are suppressed while reset is asserted so no beat leaks into a reset edge.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (i_rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (!i_alu_busy) begin
            if (i_req0_valid && i_req1_valid) begin
              grant0 = last_q;
              grant1 = ~last_q;
            end else begin
              grant0 = i_req0_valid;
              grant1 = i_req1_valid;
            end
          end
        end
        MAT_ISSUE: begin
          grant0 = ~owner_q;
          grant1 = owner_q;
        end
        default: begin
          grant0 = 1'b0;
          grant1 = 1'b0;
        end
      endcase
    end
  end

  assign hs0        = i_req0_valid & grant0;
  assign hs1        = i_req1_valid & grant1;
  assign hs_any     = hs0 | hs1;
  assign hs_inst    = hs1 ? i_req1_inst : i_req0_inst;
  assign beat_cnt_d = beat_cnt_q + 3'd1;
  assign rsp_cnt_d  = rsp_cnt_q + 4'd1;

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  always_comb begin
    o_alu_valid = hs_any;
    o_alu_inst  = '0;
    o_alu_a     = '0;
    o_alu_b     = '0;
    if (hs0) begin
      o_alu_inst = i_req0_inst;
      o_alu_a    = i_req0_a;
      o_alu_b    = i_req0_b;
    end else if (hs1) begin
      o_alu_inst = i_req1_inst;
      o_alu_a    = i_req1_a;
      o_alu_b    = i_req1_b;
    end
    if (hs_any && (state_q == MAT_ISSUE)) begin
      o_alu_inst = MAT_INST;
    end
  end

`ifdef ALU_ARB_TIMEOUT_EN
  // Firing at count 62 puts the registered pulse 64 cycles after the issuing handshake.
  localparam logic [6:0] WDOG_LAST = 7'd62;
  logic [6:0] wdog_q;
  logic [6:0] wdog_d;
  logic       timeout_q;
  assign wdog_d    = wdog_q + 7'd1;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      beat_cnt_q   <= '0;
      rsp_cnt_q    <= '0;
      rsp_exp_q    <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_data_q   <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
      wdog_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      timeout_q    <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (hs_any) begin
            owner_q   <= hs1;
            last_q    <= hs1;
            rsp_cnt_q <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            wdog_q    <= '0;
`endif
            if (hs_inst == MAT_INST) begin
              beat_cnt_q <= 3'd1;
              rsp_exp_q  <= 4'd8;
              state_q    <= MAT_ISSUE;
            end else begin
              rsp_exp_q  <= 4'd1;
              state_q    <= WAIT_RSP;
            end
          end
        end
        MAT_ISSUE: begin
          if (hs_any) begin
            beat_cnt_q <= beat_cnt_d;
            if (beat_cnt_q == 3'd7) begin
              state_q <= WAIT_RSP;
`ifdef ALU_ARB_TIMEOUT_EN
              wdog_q  <= '0;
`endif
            end
          end
        end
        WAIT_RSP: begin
          if (i_alu_out_valid) begin
            rsp_cnt_q    <= rsp_cnt_d;
            rsp_data_q   <= i_alu_data;
            rsp0_valid_q <= ~owner_q;
            rsp1_valid_q <= owner_q;
`ifdef ALU_ARB_TIMEOUT_EN
            wdog_q       <= '0;
`endif
            if (rsp_cnt_d == rsp_exp_q) begin
              state_q <= IDLE;
            end
          end
`ifdef ALU_ARB_TIMEOUT_EN
          else if (wdog_q == WDOG_LAST) begin
            timeout_q <= 1'b1;
            wdog_q    <= '0;
            state_q   <= IDLE;
          end else begin
            wdog_q    <= wdog_d;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp_data   = rsp_data_q;

endmodule
